// File: rtl/riscv_ex_stage.sv
// RISC-V execute stage: operand resolution, ALU evaluation and a 2-entry (main + skid) EX/MEM buffer.
// Optional MEM/WB forwarding muxes are built when RISCV_EX_FORWARD_EN is defined.
`timescale 1ns/1ps

module riscv_alu #(
    parameter int XLEN = 64
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_overflow
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_SLL = 4'd2,  OP_SLT = 4'd3,
                           OP_SLTU = 4'd4, OP_XOR  = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7,
                           OP_OR  = 4'd8,  OP_AND  = 4'd9,  OP_LUI = 4'd10, OP_AUIPC = 4'd11;

    logic signed [XLEN-1:0] w_a_s;
    logic signed [XLEN-1:0] w_b_s;
    logic [SHW-1:0]         w_shamt;
    logic [XLEN-1:0]        w_sum;
    logic [XLEN-1:0]        w_diff;

    assign w_a_s   = i_a;
    assign w_b_s   = i_b;
    assign w_shamt = i_b[SHW-1:0];
    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result   = w_sum;
                o_overflow = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
            end
            OP_SUB: begin
                o_result   = w_diff;
                o_overflow = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_diff[XLEN-1] != i_a[XLEN-1]);
            end
            OP_SLL:   o_result = i_a << w_shamt;
            OP_SLT:   o_result = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
            OP_SLTU:  o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            OP_XOR:   o_result = i_a ^ i_b;
            OP_SRL:   o_result = i_a >> w_shamt;
            OP_SRA:   o_result = w_a_s >>> w_shamt;
            OP_OR:    o_result = i_a | i_b;
            OP_AND:   o_result = i_a & i_b;
            OP_LUI:   o_result = i_b;
            OP_AUIPC: o_result = w_sum;
            default:  o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);
endmodule

module riscv_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_rd_we,
    input  logic [3:0]      in_alu_op,
    input  logic            in_a_sel_pc,
    input  logic            in_b_sel_imm,
    input  logic            fwd_mem_we,
    input  logic            fwd_wb_we,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_overflow,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd_addr,
    output logic            out_rd_we
);
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            ovf;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            we;
    } entry_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_in_ready;
    logic            w_acc;
    logic            w_vld_p1;
    logic            w_ld_main_new;
    logic            w_ld_skid;
    logic            w_skid_to_main;

    logic [XLEN-1:0] w_rs1_p0;
    logic [XLEN-1:0] w_rs2_p0;
    logic [XLEN-1:0] w_a_p0;
    logic [XLEN-1:0] w_b_p0;
    logic [XLEN-1:0] w_result_p0;
    logic            w_zero_p0;
    logic            w_ovf_p0;
    entry_t          w_ent_p0;
    entry_t          r_main_p1;
    entry_t          r_skid_p1;

    // ---- Stage p0: operand resolution and ALU in the accept cycle ----
`ifdef RISCV_EX_FORWARD_EN
    always_comb begin
        if (fwd_mem_we && (fwd_mem_rd == in_rs1_addr) && (in_rs1_addr != 5'd0))
            w_rs1_p0 = fwd_mem_data;
        else if (fwd_wb_we && (fwd_wb_rd == in_rs1_addr) && (in_rs1_addr != 5'd0))
            w_rs1_p0 = fwd_wb_data;
        else
            w_rs1_p0 = in_rs1_val;

        if (fwd_mem_we && (fwd_mem_rd == in_rs2_addr) && (in_rs2_addr != 5'd0))
            w_rs2_p0 = fwd_mem_data;
        else if (fwd_wb_we && (fwd_wb_rd == in_rs2_addr) && (in_rs2_addr != 5'd0))
            w_rs2_p0 = fwd_wb_data;
        else
            w_rs2_p0 = in_rs2_val;
    end
`else
    // Hazards are resolved by ID stalls in this build, so the forwarding ports are inert.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_mem_we, fwd_wb_we, fwd_mem_rd, fwd_wb_rd,
                            fwd_mem_data, fwd_wb_data, in_rs1_addr, in_rs2_addr};
    assign w_rs1_p0 = in_rs1_val;
    assign w_rs2_p0 = in_rs2_val;
`endif

    assign w_a_p0 = in_a_sel_pc  ? in_pc  : w_rs1_p0;
    assign w_b_p0 = in_b_sel_imm ? in_imm : w_rs2_p0;

    riscv_alu #(.XLEN(XLEN)) u_alu (
        .i_op       (in_alu_op),
        .i_a        (w_a_p0),
        .i_b        (w_b_p0),
        .o_result   (w_result_p0),
        .o_zero     (w_zero_p0),
        .o_overflow (w_ovf_p0)
    );

    assign w_ent_p0 = '{result: w_result_p0, zero: w_zero_p0, ovf: w_ovf_p0, pc: in_pc,
                        rd: in_rd_addr, we: in_rd_we && (in_rd_addr != 5'd0)};

    assign w_acc = in_valid && r_in_ready && !flush;

    // ---- Stage p1: EX/MEM buffer control ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_FULL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_acc) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_acc && !out_ready)      w_state_nxt = S_FULL;
                    else if (!w_acc && out_ready) w_state_nxt = S_EMPTY;
                end
                S_FULL:  if (out_ready) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_vld_p1       = (r_state != S_EMPTY);
        w_ld_main_new  = w_acc && ((r_state == S_EMPTY) || ((r_state == S_ONE) && out_ready));
        w_ld_skid      = w_acc && (r_state == S_ONE) && !out_ready;
        w_skid_to_main = !flush && (r_state == S_FULL) && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_p1 <= '0;
            r_skid_p1 <= '0;
        end else begin
            if (w_ld_main_new)
                r_main_p1 <= w_ent_p0;
            else if (w_skid_to_main)
                r_main_p1 <= r_skid_p1;
            if (w_ld_skid)
                r_skid_p1 <= w_ent_p0;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = w_vld_p1;
    assign out_result   = r_main_p1.result;
    assign out_zero     = r_main_p1.zero;
    assign out_overflow = r_main_p1.ovf;
    assign out_pc       = r_main_p1.pc;
    assign out_rd_addr  = r_main_p1.rd;
    assign out_rd_we    = r_main_p1.we;
endmodule

// File: tb/tb_riscv_ex_stage.sv
// Bench for riscv_ex_stage: directed steps plus random traffic against a queue-based reference model.
`timescale 1ns/1ps

module tb_riscv_ex_stage;
    logic        clk;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_zero, out_overflow, out_rd_we;
    logic [63:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic        in_rd_we, in_a_sel_pc, in_b_sel_imm;
    logic [3:0]  in_alu_op;
    logic        fwd_mem_we, fwd_wb_we;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [63:0] fwd_mem_data, fwd_wb_data;
    logic [63:0] out_result, out_pc;
    logic [4:0]  out_rd_addr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] res;
        logic        z;
        logic        o;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t q[$];
    logic m_in_ready;

    riscv_ex_stage #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rd_we(in_rd_we), .in_alu_op(in_alu_op),
        .in_a_sel_pc(in_a_sel_pc), .in_b_sel_imm(in_b_sel_imm),
        .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
        .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow),
        .out_pc(out_pc), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] opnd(input logic [4:0] addr, input logic [63:0] rf);
`ifdef RISCV_EX_FORWARD_EN
        if (addr != 0 && fwd_mem_we && fwd_mem_rd == addr) return fwd_mem_data;
        if (addr != 0 && fwd_wb_we && fwd_wb_rd == addr)   return fwd_wb_data;
`endif
        return rf;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic [63:0] a, b, r;
        logic signed [64:0] w;
        logic ov;
        a  = in_a_sel_pc  ? in_pc  : opnd(in_rs1_addr, in_rs1_val);
        b  = in_b_sel_imm ? in_imm : opnd(in_rs2_addr, in_rs2_val);
        ov = 1'b0;
        r  = 64'd0;
        case (in_alu_op)
            4'd0:  begin w = $signed({a[63], a}) + $signed({b[63], b}); r = w[63:0]; ov = (w[64] != w[63]); end
            4'd1:  begin w = $signed({a[63], a}) - $signed({b[63], b}); r = w[63:0]; ov = (w[64] != w[63]); end
            4'd2:  r = a << b[5:0];
            4'd3:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd4:  r = (a < b) ? 64'd1 : 64'd0;
            4'd5:  r = a ^ b;
            4'd6:  r = a >> b[5:0];
            4'd7:  r = $signed(a) >>> b[5:0];
            4'd8:  r = a | b;
            4'd9:  r = a & b;
            4'd10: r = b;
            4'd11: r = a + b;
            default: r = 64'd0;
        endcase
        e.res = r;
        e.z   = (r == 64'd0);
        e.o   = ov;
        e.pc  = in_pc;
        e.rd  = in_rd_addr;
        e.we  = in_rd_we && (in_rd_addr != 5'd0);
        return e;
    endfunction

    // One clock: update the model from the inputs presented before the edge, then compare after it.
    task automatic cycle();
        exp_t e;
        logic acc;
        e   = predict();
        acc = in_valid && m_in_ready && !flush;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_in_ready = 1'b0;
        end else if (flush) begin
            q.delete();
            m_in_ready = 1'b1;
        end else begin
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(e);
            m_in_ready = (q.size() < 2);
        end
        #1;
        chk("out_valid", out_valid, (q.size() > 0));
        chk("in_ready", in_ready, m_in_ready);
        if (q.size() > 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_zero", out_zero, q[0].z);
            chk("out_overflow", out_overflow, q[0].o);
            chk("out_pc", out_pc, q[0].pc);
            chk("out_rd_addr", out_rd_addr, q[0].rd);
            chk("out_rd_we", out_rd_we, q[0].we);
        end
    endtask

    task automatic set_instr(input logic [3:0] op, input logic a_pc, input logic b_imm,
                             input logic [63:0] pc, input logic [63:0] r1, input logic [63:0] r2,
                             input logic [63:0] imm, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [4:0] rd, input logic we);
        in_alu_op = op; in_a_sel_pc = a_pc; in_b_sel_imm = b_imm; in_pc = pc;
        in_rs1_val = r1; in_rs2_val = r2; in_imm = imm;
        in_rs1_addr = a1; in_rs2_addr = a2; in_rd_addr = rd; in_rd_we = we;
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] fwd_exp;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fwd_mem_we = 1'b0; fwd_wb_we = 1'b0; fwd_mem_rd = '0; fwd_wb_rd = '0;
        fwd_mem_data = '0; fwd_wb_data = '0;
        set_instr(4'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        m_in_ready = 1'b0;

        // Reset state
        repeat (2) cycle();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_rd", {out_rd_we, out_rd_addr, out_zero, out_overflow}, 64'd0);
        rst = 1'b0;
        cycle();
        chk("post_rst_in_ready", in_ready, 1'b1);

        // ADD 5 + 7
        out_ready = 1'b1;
        set_instr(4'd0, 1'b0, 1'b0, 64'h40, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd4, 1'b1);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1'b1);
        chk("add_result", out_result, 64'd12);
        chk("add_zero", out_zero, 1'b0);
        cycle();
        chk("idle_valid", out_valid, 1'b0);

        // SUB overflow
        set_instr(4'd1, 1'b0, 1'b0, 64'h44, 64'h7FFF_FFFF_FFFF_FFFF, '1, 64'd0, 5'd1, 5'd2, 5'd5, 1'b1);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("sub_result", out_result, 64'h8000_0000_0000_0000);
        chk("sub_ovf", out_overflow, 1'b1);

        // Forwarding priority and x0
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 64'd100;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd3; fwd_wb_data  = 64'd200;
`ifdef RISCV_EX_FORWARD_EN
        fwd_exp = 64'd101;
`else
        fwd_exp = 64'd51;
`endif
        set_instr(4'd0, 1'b0, 1'b1, 64'h48, 64'd50, 64'd9, 64'd1, 5'd3, 5'd0, 5'd6, 1'b1);
        in_valid = 1'b1;
        cycle();
        chk("fwd_rs1", out_result, fwd_exp);
        fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
        set_instr(4'd0, 1'b0, 1'b1, 64'h4C, 64'd50, 64'd9, 64'd1, 5'd0, 5'd0, 5'd6, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("fwd_x0", out_result, 64'd51);
        fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;
        cycle();

        // Backpressure: three back-to-back with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_instr(4'd0, 1'b0, 1'b1, 64'h100, 64'd1, 64'd0, 64'd1, 5'd1, 5'd0, 5'd7, 1'b1);
        cycle();
        set_instr(4'd0, 1'b0, 1'b1, 64'h104, 64'd2, 64'd0, 64'd2, 5'd1, 5'd0, 5'd8, 1'b1);
        cycle();
        chk("bp_full_ready", in_ready, 1'b0);
        set_instr(4'd0, 1'b0, 1'b1, 64'h108, 64'd3, 64'd0, 64'd3, 5'd1, 5'd0, 5'd9, 1'b1);
        cycle();
        chk("bp_hold_pc", out_pc, 64'h100);
        chk("bp_hold_result", out_result, 64'd2);
        out_ready = 1'b1;
        cycle();
        chk("bp_second_pc", out_pc, 64'h104);
        chk("bp_reready", in_ready, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("bp_third_pc", out_pc, 64'h108);
        chk("bp_third_result", out_result, 64'd6);
        cycle();
        chk("bp_drained", out_valid, 1'b0);

        // Flush while FULL with a concurrent input, then flush while ONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_instr(4'd5, 1'b0, 1'b0, 64'h200, 64'hF0, 64'h0F, 64'd0, 5'd1, 5'd2, 5'd10, 1'b1);
        cycle();
        set_instr(4'd8, 1'b0, 1'b0, 64'h204, 64'hF0, 64'h0F, 64'd0, 5'd1, 5'd2, 5'd11, 1'b1);
        cycle();
        flush = 1'b1;
        set_instr(4'd9, 1'b0, 1'b0, 64'h208, 64'hF0, 64'h0F, 64'd0, 5'd1, 5'd2, 5'd12, 1'b1);
        cycle();
        chk("flush_full_valid", out_valid, 1'b0);
        chk("flush_full_ready", in_ready, 1'b1);
        flush = 1'b0;
        cycle();
        flush = 1'b1;
        set_instr(4'd0, 1'b0, 1'b0, 64'h20C, 64'd1, 64'd1, 64'd0, 5'd1, 5'd2, 5'd13, 1'b1);
        cycle();
        chk("flush_one_valid", out_valid, 1'b0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        chk("flush_dropped", out_valid, 1'b0);

        // AUIPC, LUI, rd=x0
        in_valid = 1'b1;
        set_instr(4'd11, 1'b1, 1'b1, 64'h1000, 64'd0, 64'd0, 64'h2000, 5'd0, 5'd0, 5'd14, 1'b1);
        cycle();
        chk("auipc", out_result, 64'h3000);
        set_instr(4'd10, 1'b0, 1'b1, 64'h1004, 64'd77, 64'd0, 64'hABCD_E000, 5'd1, 5'd0, 5'd15, 1'b1);
        cycle();
        chk("lui", out_result, 64'hABCD_E000);
        set_instr(4'd0, 1'b0, 1'b0, 64'h1008, 64'd1, 64'd2, 64'd0, 5'd1, 5'd2, 5'd0, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("rd0_we", out_rd_we, 1'b0);
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            set_instr(4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      rand64(), rand64(), rand64(), rand64(),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            fwd_mem_we = 1'($urandom_range(0, 1)); fwd_mem_rd = 5'($urandom_range(0, 3));
            fwd_wb_we  = 1'($urandom_range(0, 1)); fwd_wb_rd  = 5'($urandom_range(0, 3));
            fwd_mem_data = rand64(); fwd_wb_data = rand64();
            if (i == 300) rst = 1'b1;
            if (i == 302) rst = 1'b0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/riscv_ex_stage.md
# riscv_ex_stage

Execute stage wrapper for the RISC-V core: accepts decoded instructions from ID over a valid/ready handshake, resolves operands (register file, PC, immediate, MEM/WB forwarding), evaluates them with a `riscv_alu` instance, and registers the result into the EX/MEM boundary. It is the stage that feeds `riscv_alu` and consumes its result. A 2-entry output buffer (main + skid) keeps `in_ready` registered and free of combinational paths from `out_ready`.

## Interface
- XLEN, 64, datapath width; passed to `riscv_alu`
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all buffered instructions (branch mispredict/trap)
- in_valid  input  1  ID presents an instruction
- in_ready  output  1  stage can accept; registered
- in_pc  input  XLEN  instruction PC
- in_rs1_val / in_rs2_val  input  XLEN  register file read data
- in_imm  input  XLEN  decoded immediate, already shifted for LUI/AUIPC
- in_rs1_addr / in_rs2_addr / in_rd_addr  input  5  register indices
- in_rd_we  input  1  instruction writes rd
- in_alu_op  input  4  ALU opcode (ADD=0 … AUIPC=11)
- in_a_sel_pc  input  1  operand A = in_pc instead of rs1
- in_b_sel_imm  input  1  operand B = in_imm instead of rs2
- fwd_mem_we / fwd_wb_we  input  1  MEM/WB stage writes rd this cycle
- fwd_mem_rd / fwd_wb_rd  input  5  MEM/WB destination index
- fwd_mem_data / fwd_wb_data  input  XLEN  MEM/WB result
- out_valid  output  1  EX/MEM entry valid
- out_ready  input  1  MEM consumes entry
- out_result  output  XLEN  ALU result
- out_zero / out_overflow  output  1  ALU flags
- out_pc  output  XLEN  PC of the instruction
- out_rd_addr  output  5  destination index
- out_rd_we  output  1  write enable (forced 0 when rd=0)

## Operation
- Accept: `acc = in_valid & in_ready & ~flush`. Operands, ALU result, and flags are computed combinationally in the accept cycle and captured; nothing is recomputed later.
- Operand A = `in_a_sel_pc ? in_pc : rs1_fwd`; B = `in_b_sel_imm ? in_imm : rs2_fwd`.
- Forward for rsN:
  - MEM if `fwd_mem_we & fwd_mem_rd==rsN & rsN!=0`;
  - else WB under the same rule;
  - else `in_rsN_val`.
  - MEM has priority over WB. x0 is never forwarded.
- Storage: main register (drives outputs) + skid register. States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY + acc → ONE.
  - ONE + acc + out_ready → ONE (main replaced).
  - ONE + acc + ~out_ready → FULL (new entry to skid).
  - ONE + out_ready + ~acc → EMPTY.
  - FULL + out_ready → ONE (skid moves to main). acc impossible in FULL.
- `in_ready` = registered `~FULL` of the next state.
- `out_rd_we = in_rd_we & (in_rd_addr != 0)`, captured at accept.
- Flush: next state EMPTY, both valids cleared, any concurrent input dropped. Flush has priority over acc and out_ready.
- Reset:
  - out_valid=0, in_ready=0 during reset, 1 the cycle after.
  - all data outputs 0, state EMPTY.
  - Reset mid-transfer drops all entries.

## Timing
- Latency: 1 cycle accept → out_valid when buffer empty or draining.
- Throughput: 1 instr/cycle while out_ready=1.
- Outputs held stable while `out_valid & ~out_ready`.
- No combinational path from out_ready to in_ready. The only combinational paths are forwarding inputs → captured data.
- After FULL, in_ready reasserts in the cycle after out_ready was sampled high.

## Configuration
- `RISCV_EX_FORWARD_EN` defined: forwarding muxes as above.
- Undefined: rsN_fwd = `in_rsN_val`. fwd_* inputs are ignored, and the hazard check moves to the ID stall logic. All other behaviour is identical.

## Test plan
- Reset, then ADD with rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, out_result=12, zero=0; idle after → out_valid=0.
- SUB with rs1=0x7FFF_FFFF_FFFF_FFFF, rs2=-1 → out_result=0x8000_0000_0000_0000, out_overflow=1.
- Forward: in_rs1_addr=3, fwd_mem(rd3, 100), fwd_wb(rd3, 200), ADD with imm 1 → result 101; same with rs1_addr=0 → in_rs1_val+1. With macro undefined → in_rs1_val+1.
- Backpressure: out_ready=0, issue 3 back-to-back → first two accepted (FULL), in_ready=0 next cycle, third held. out_ready=1 → results emerge in order, third accepted, no loss or duplication.
- Flush while FULL with concurrent in_valid → next cycle out_valid=0, in_ready=1, the flushed input never appears.
- AUIPC pc=0x1000, imm=0x2000 → 0x3000. LUI imm=0xABCD_E000 → 0xABCD_E000. rd=0 with we=1 → out_rd_we=0.
